// File: rtl/fp_sub_seq.sv
// rtl/fp_sub_seq.sv - multi-cycle binary32 subtractor (res = a - b), truncating, with iterative normalization
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic        r_sa;
  logic        r_sb;
  logic [7:0]  r_ea;
  logic [7:0]  r_eb;
  logic [23:0] r_ma;
  logic [23:0] r_mb;
  logic        r_special;
  logic [7:0]  r_exp;
  logic [24:0] r_mc;
  logic        r_sign;
  logic [31:0] r_res;

  logic        w_ea_ge;
  logic [7:0]  w_diff;
  logic [23:0] w_small_m;
  logic [23:0] w_aligned;
  logic [24:0] w_sum;
  logic [7:0]  w_exp_inc;
  logic        w_accept;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign res       = r_res;
  assign w_accept  = in_valid && (r_state == S_IDLE);

  // Shifts of 24 or more would leave nothing of the smaller mantissa.
  assign w_ea_ge   = (r_ea >= r_eb);
  assign w_diff    = w_ea_ge ? (r_ea - r_eb) : (r_eb - r_ea);
  assign w_small_m = w_ea_ge ? r_mb : r_ma;
  assign w_aligned = (w_diff >= 8'd24) ? 24'd0 : (w_small_m >> w_diff);

  assign w_sum     = {1'b0, r_ma} + {1'b0, r_mb};
  assign w_exp_inc = r_exp + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_ea      <= 8'd0;
      r_eb      <= 8'd0;
      r_ma      <= 24'd0;
      r_mb      <= 24'd0;
      r_special <= 1'b0;
      r_exp     <= 8'd0;
      r_mc      <= 25'd0;
      r_sign    <= 1'b0;
      r_res     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sa      <= a[31];
            r_sb      <= ~b[31];
            r_ea      <= a[30:23];
            r_eb      <= b[30:23];
            r_ma      <= (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
            r_mb      <= (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
            r_special <= (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
            r_state   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_ea_ge) begin
            r_exp <= r_ea;
            r_mb  <= w_aligned;
          end else begin
            r_exp <= r_eb;
            r_ma  <= w_aligned;
          end
          r_state <= S_OP;
        end
        S_OP: begin
          if (r_sa == r_sb) begin
            r_mc   <= w_sum;
            r_sign <= r_sa;
          end else if (r_ma > r_mb) begin
            r_mc   <= {1'b0, r_ma - r_mb};
            r_sign <= r_sa;
          end else if (r_mb > r_ma) begin
            r_mc   <= {1'b0, r_mb - r_ma};
            r_sign <= r_sb;
          end else begin
            r_mc   <= 25'd0;
            r_sign <= 1'b0;
          end
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_special) begin
            r_res   <= 32'h7FC0_0000;
            r_state <= S_DONE;
          end else if (r_mc == 25'd0) begin
            r_res   <= {r_sa & r_sb, 31'd0};
            r_state <= S_DONE;
          end else if (r_mc[24]) begin
            r_exp   <= w_exp_inc;
            r_mc    <= r_mc >> 1;
            r_res   <= (w_exp_inc == 8'hFF) ? {r_sign, 8'hFF, 23'd0}
                                            : {r_sign, w_exp_inc, r_mc[23:1]};
            r_state <= S_DONE;
          end else if (r_mc[23]) begin
            r_res   <= {r_sign, r_exp, r_mc[22:0]};
            r_state <= S_DONE;
          end else if (r_exp == 8'd1) begin
            // Would need a denormal; flush to a signed zero instead.
            r_res   <= {r_sign, 31'd0};
            r_state <= S_DONE;
          end else begin
            r_mc  <= r_mc << 1;
            r_exp <= r_exp - 8'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
